// File: rtl/truth_table_capture_if.sv
// Handshake and data bundle between a truth-table sweeper and the function under test.
// The master side drives start/f/exp; the slave side (the sweeper) drives the vector and results.
interface truth_table_capture_if;
    logic        start;
    logic        f;
    logic [15:0] exp;
    logic        A;
    logic        B;
    logic        C;
    logic        D;
    logic        busy;
    logic        done;
    logic [15:0] tt;
    logic [4:0]  ones;
    logic        mismatch;
    logic [3:0]  mis_idx;

    modport master (
        output start, f, exp,
        input  A, B, C, D, busy, done, tt, ones, mismatch, mis_idx
    );

    modport slave (
        input  start, f, exp,
        output A, B, C, D, busy, done, tt, ones, mismatch, mis_idx
    );
endinterface

// File: rtl/truth_table_capture.sv
// Sweeps all 16 input vectors of a 4-input function, lets each settle, and captures the
// resulting truth table together with a ones count and a first-mismatch report.
module truth_table_capture #(
    parameter int unsigned SETTLE = 2
) (
    input logic                  clk,
    input logic                  rst,
    truth_table_capture_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StSettle, StSample, StDone} state_e;

    localparam logic [3:0] WcntLast = 4'(SETTLE - 1);

    state_e      state_q;
    logic [3:0]  idx_q;
    logic [3:0]  wcnt_q;
    logic [15:0] tt_q;
    logic [4:0]  ones_q;
    logic        mismatch_q;
    logic [3:0]  mis_idx_q;
    logic        busy_q;
    logic        done_q;
    logic [3:0]  vec_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            idx_q      <= 4'd0;
            wcnt_q     <= 4'd0;
            tt_q       <= 16'd0;
            ones_q     <= 5'd0;
            mismatch_q <= 1'b0;
            mis_idx_q  <= 4'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            vec_q      <= 4'd0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        idx_q      <= 4'd0;
                        wcnt_q     <= 4'd0;
                        tt_q       <= 16'd0;
                        ones_q     <= 5'd0;
                        mismatch_q <= 1'b0;
                        mis_idx_q  <= 4'd0;
                        busy_q     <= 1'b1;
                        vec_q      <= 4'd0;
                        state_q    <= StSettle;
                    end
                end
                StSettle: begin
                    wcnt_q <= wcnt_q + 4'd1;
                    if (wcnt_q == WcntLast) begin
                        state_q <= StSample;
                    end
                end
                StSample: begin
                    tt_q[idx_q] <= bus.f;
                    // At most 16 samples, so the 5-bit count cannot wrap.
                    ones_q      <= ones_q + {4'd0, bus.f};
                    if ((bus.f != bus.exp[idx_q]) && !mismatch_q) begin
                        mismatch_q <= 1'b1;
                        mis_idx_q  <= idx_q;
                    end
                    if (idx_q == 4'd15) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        vec_q   <= 4'd0;
                        state_q <= StDone;
                    end else begin
                        idx_q   <= idx_q + 4'd1;
                        wcnt_q  <= 4'd0;
                        vec_q   <= idx_q + 4'd1;
                        state_q <= StSettle;
                    end
                end
                StDone: begin
                    done_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus.A        = vec_q[3];
    assign bus.B        = vec_q[2];
    assign bus.C        = vec_q[1];
    assign bus.D        = vec_q[0];
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.tt       = tt_q;
    assign bus.ones     = ones_q;
    assign bus.mismatch = mismatch_q;
    assign bus.mis_idx  = mis_idx_q;

endmodule

// File: tb/tb_truth_table_capture.sv
// Directed bench: one DUT with SETTLE=2 for function/result checks, one with SETTLE=1 for
// vector sequencing and timing.
module tb_truth_table_capture;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;
    int   f_mode;

    truth_table_capture_if bus1 ();
    truth_table_capture_if bus2 ();

    truth_table_capture #(.SETTLE(2)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
    truth_table_capture #(.SETTLE(1)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

    logic [3:0] vec1;
    logic [3:0] vec2;
    assign vec1 = {bus1.A, bus1.B, bus1.C, bus1.D};
    assign vec2 = {bus2.A, bus2.B, bus2.C, bus2.D};

    // f_mode 0: parity, 1: constant one, 2: parity inverted at vectors 5 and 9
    assign bus1.f = (f_mode == 1) ? 1'b1 :
                    ((^vec1) ^ ((f_mode == 2) && (vec1 == 4'd5 || vec1 == 4'd9)));
    assign bus2.f = ^vec2;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Start a sweep on dut1; edges counts clock edges after the accepting edge until done.
    task automatic run_sweep(output int edges);
        edges = -1;
        @(negedge clk);
        bus1.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus1.start = 1'b0;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            if (bus1.done) begin
                edges = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus1.start = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (bus1.busy !== 1'b0 || bus1.done !== 1'b0 || vec1 !== 4'd0) begin
            $display("FAIL reset_ctrl: busy=%b done=%b vec=%h, want 0 0 0",
                     bus1.busy, bus1.done, vec1);
        end else n_pass++;
        n_checks++;
        if (bus1.tt !== 16'd0 || bus1.ones !== 5'd0 || bus1.mismatch !== 1'b0 ||
            bus1.mis_idx !== 4'd0) begin
            $display("FAIL reset_results: tt=%h ones=%0d mm=%b mi=%0d, want all 0",
                     bus1.tt, bus1.ones, bus1.mismatch, bus1.mis_idx);
        end else n_pass++;
        bus1.start = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus1.busy !== 1'b0) begin
            $display("FAIL reset_idle_no_start: busy=%b, want 0", bus1.busy);
        end else n_pass++;
    endtask

    task automatic test_parity();
        int edges;
        f_mode = 0;
        bus1.exp = 16'h6996;
        run_sweep(edges);
        n_checks++;
        if (edges !== 48) $display("FAIL parity_done_edge: got %0d, want 48", edges);
        else n_pass++;
        n_checks++;
        if (bus1.tt !== 16'h6996 || bus1.ones !== 5'd8 || bus1.mismatch !== 1'b0) begin
            $display("FAIL parity_result: tt=%h ones=%0d mm=%b, want 6996 8 0",
                     bus1.tt, bus1.ones, bus1.mismatch);
        end else n_pass++;
        n_checks++;
        if (bus1.busy !== 1'b0 || vec1 !== 4'd0) begin
            $display("FAIL parity_done_outputs: busy=%b vec=%h, want 0 0", bus1.busy, vec1);
        end else n_pass++;
        bus1.exp = 16'h0000;
        repeat (3) @(negedge clk);
        n_checks++;
        if (bus1.done !== 1'b0 || bus1.tt !== 16'h6996 || bus1.ones !== 5'd8 ||
            bus1.mismatch !== 1'b0) begin
            $display("FAIL parity_hold: done=%b tt=%h ones=%0d mm=%b, want 0 6996 8 0",
                     bus1.done, bus1.tt, bus1.ones, bus1.mismatch);
        end else n_pass++;
    endtask

    task automatic test_all_ones();
        int edges;
        f_mode = 1;
        bus1.exp = 16'hFFFF;
        run_sweep(edges);
        n_checks++;
        if (edges !== 48) $display("FAIL ones_done_edge: got %0d, want 48", edges);
        else n_pass++;
        n_checks++;
        if (bus1.tt !== 16'hFFFF || bus1.ones !== 5'd16 || bus1.mismatch !== 1'b0) begin
            $display("FAIL ones_result: tt=%h ones=%0d mm=%b, want ffff 16 0",
                     bus1.tt, bus1.ones, bus1.mismatch);
        end else n_pass++;
    endtask

    task automatic test_mismatch();
        int edges;
        f_mode = 2;
        bus1.exp = 16'h6996;
        run_sweep(edges);
        n_checks++;
        if (edges !== 48) $display("FAIL mm_done_edge: got %0d, want 48", edges);
        else n_pass++;
        n_checks++;
        if (bus1.tt !== 16'h6BB6 || bus1.ones !== 5'd10) begin
            $display("FAIL mm_table: tt=%h ones=%0d, want 6bb6 10", bus1.tt, bus1.ones);
        end else n_pass++;
        n_checks++;
        if (bus1.mismatch !== 1'b1 || bus1.mis_idx !== 4'd5) begin
            $display("FAIL mm_first: mm=%b mi=%0d, want 1 5", bus1.mismatch, bus1.mis_idx);
        end else n_pass++;
    endtask

    task automatic test_sequence();
        int busy_cnt;
        int bad;
        busy_cnt = 0;
        bad = 0;
        @(negedge clk);
        bus2.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus2.start = 1'b0;
        for (int k = 0; k <= 40; k++) begin
            if (k > 0) @(negedge clk);
            if (bus2.busy) busy_cnt++;
            if (k < 32) begin
                if (bus2.busy !== 1'b1 || vec2 !== 4'(k / 2) || bus2.done !== 1'b0) bad++;
            end else if (k == 32) begin
                n_checks++;
                if (bus2.done !== 1'b1 || vec2 !== 4'd0 || bus2.busy !== 1'b0) begin
                    $display("FAIL seq_done: done=%b busy=%b vec=%h, want 1 0 0",
                             bus2.done, bus2.busy, vec2);
                end else n_pass++;
            end else if (bus2.done !== 1'b0 || vec2 !== 4'd0) bad++;
        end
        n_checks++;
        if (bad != 0) $display("FAIL seq_vectors: %0d bad cycles, want 0", bad);
        else n_pass++;
        n_checks++;
        if (busy_cnt != 32) $display("FAIL seq_busy_len: got %0d, want 32", busy_cnt);
        else n_pass++;
        n_checks++;
        if (bus2.tt !== 16'h6996 || bus2.ones !== 5'd8) begin
            $display("FAIL seq_result: tt=%h ones=%0d, want 6996 8", bus2.tt, bus2.ones);
        end else n_pass++;
    endtask

    task automatic test_restart_ignored();
        int first;
        int pulses;
        first = -1;
        pulses = 0;
        f_mode = 0;
        bus1.exp = 16'h6996;
        @(negedge clk);
        bus1.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus1.start = 1'b0;
        for (int k = 1; k <= 70; k++) begin
            @(negedge clk);
            bus1.start = (k == 10);
            if (bus1.done) begin
                pulses++;
                if (first < 0) first = k;
            end
        end
        bus1.start = 1'b0;
        n_checks++;
        if (first != 48) $display("FAIL restart_timing: done at %0d, want 48", first);
        else n_pass++;
        n_checks++;
        if (pulses != 1) $display("FAIL restart_pulses: got %0d, want 1", pulses);
        else n_pass++;
    endtask

    task automatic test_reset_mid_sweep();
        int pulses;
        int edges;
        pulses = 0;
        f_mode = 2;
        bus1.exp = 16'h6996;
        @(negedge clk);
        bus1.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus1.start = 1'b0;
        repeat (21) @(negedge clk);
        n_checks++;
        if (vec1 !== 4'd7 || bus1.busy !== 1'b1) begin
            $display("FAIL abort_pre: vec=%h busy=%b, want 7 1", vec1, bus1.busy);
        end else n_pass++;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if (bus1.busy !== 1'b0 || bus1.done !== 1'b0 || vec1 !== 4'd0 || bus1.tt !== 16'd0 ||
            bus1.ones !== 5'd0 || bus1.mismatch !== 1'b0 || bus1.mis_idx !== 4'd0) begin
            $display("FAIL abort_clear: busy=%b done=%b vec=%h tt=%h ones=%0d mm=%b mi=%0d",
                     bus1.busy, bus1.done, vec1, bus1.tt, bus1.ones, bus1.mismatch,
                     bus1.mis_idx);
        end else n_pass++;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (bus1.done) pulses++;
        end
        n_checks++;
        if (pulses != 0) $display("FAIL abort_no_done: got %0d pulses, want 0", pulses);
        else n_pass++;
        f_mode = 0;
        run_sweep(edges);
        n_checks++;
        if (edges !== 48 || bus1.tt !== 16'h6996 || bus1.ones !== 5'd8 ||
            bus1.mismatch !== 1'b0) begin
            $display("FAIL abort_resweep: edge=%0d tt=%h ones=%0d mm=%b, want 48 6996 8 0",
                     edges, bus1.tt, bus1.ones, bus1.mismatch);
        end else n_pass++;
    endtask

    initial begin
        n_checks = 0;
        n_pass = 0;
        f_mode = 0;
        rst = 1'b1;
        bus1.start = 1'b0;
        bus1.exp = 16'h0000;
        bus2.start = 1'b0;
        bus2.exp = 16'h6996;
        test_reset();
        test_parity();
        test_all_ones();
        test_mismatch();
        test_sequence();
        test_restart_ignored();
        test_reset_mid_sweep();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
